// File: rtl/imm_ext_pkg.sv
// Shared types and constants for the immediate-extraction stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imm_ext_pkg;

   // Immediate format codes as presented on out_type.
   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5,
      IMM_Z    = 3'd6
   } imm_type_e;

   // Major opcodes, i.e. inst[6:2].
   localparam logic [4:0] OPC_LOAD      = 5'b00000;
   localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
   localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
   localparam logic [4:0] OPC_JALR      = 5'b11001;
   localparam logic [4:0] OPC_STORE     = 5'b01000;
   localparam logic [4:0] OPC_BRANCH    = 5'b11000;
   localparam logic [4:0] OPC_LUI       = 5'b01101;
   localparam logic [4:0] OPC_AUIPC     = 5'b00101;
   localparam logic [4:0] OPC_JAL       = 5'b11011;
   localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: format, extended immediate, pc-relative target.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller qualifies the result with its own handshake.
//
// Ports:
//   inst    - raw 32-bit instruction
//   pc      - XLEN-bit address of inst
//   imm     - sign/zero-extended immediate (0 when no immediate applies)
//   target  - pc + imm for B, J and AUIPC; 0 otherwise
//   itype   - format code (imm_type_e)
//   illegal - instruction cannot be handled by this stage
module imm_decode
   import imm_ext_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   input  logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] target,
   output imm_type_e       itype,
   output logic            illegal
);

   logic use_pc;

   // funct3[1:0] never influences the immediate.
   logic unused_funct3;
   assign unused_funct3 = ^inst[13:12];

   // Every format is first assembled as a 32-bit signed value, then widened
   // to XLEN; the signed cast replicates bit 31 for RV64.
   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   always_comb begin
      imm     = '0;
      itype   = IMM_NONE;
      illegal = 1'b0;
      use_pc  = 1'b0;
      // Compressed/longer encodings are rejected before the opcode is looked at.
      if (inst[1:0] != 2'b11) begin
         illegal = 1'b1;
      end else begin
         case (inst[6:2])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
               itype = IMM_I;
               imm   = sext32({{20{inst[31]}}, inst[31:20]});
            end
            OPC_OP_IMM_32: begin
               // Word ops only exist on RV64.
               if (XLEN == 64) begin
                  itype = IMM_I;
                  imm   = sext32({{20{inst[31]}}, inst[31:20]});
               end else begin
                  illegal = 1'b1;
               end
            end
            OPC_STORE: begin
               itype = IMM_S;
               imm   = sext32({{20{inst[31]}}, inst[31:25], inst[11:7]});
            end
            OPC_BRANCH: begin
               itype  = IMM_B;
               use_pc = 1'b1;
               imm    = sext32({{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                                inst[11:8], 1'b0});
            end
            OPC_LUI: begin
               itype = IMM_U;
               imm   = sext32({inst[31:12], 12'b0});
            end
            OPC_AUIPC: begin
               itype  = IMM_U;
               use_pc = 1'b1;
               imm    = sext32({inst[31:12], 12'b0});
            end
            OPC_JAL: begin
               itype  = IMM_J;
               use_pc = 1'b1;
               imm    = sext32({{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                                inst[30:21], 1'b0});
            end
            OPC_SYSTEM: begin
               // Only the CSR*I forms carry an immediate (the 5-bit uimm in rs1).
               if (inst[14]) begin
                  itype = IMM_Z;
                  imm   = XLEN'(inst[19:15]);
               end
            end
            default: ;
         endcase
      end
   end

   // Wraps modulo 2^XLEN; carry out is intentionally dropped.
   assign target = use_pc ? pc + imm : '0;

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate-extraction stage: decode on input, 2-entry FIFO to output.
// Latency: 1 cycle from accept to out_valid; outputs come straight from storage.
// Backpressure: in_ready = (count != 2), state only; no out_ready -> in_ready path.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   flush               - synchronous clear of all queued entries
//   in_valid/in_ready   - upstream handshake for in_inst/in_pc
//   out_valid/out_ready - downstream handshake for out_imm/out_target/out_type/out_illegal
//   Data outputs read 0 whenever the FIFO is empty.
module imm_ext_pipe
   import imm_ext_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_target,
   output logic [2:0]      out_type,
   output logic            out_illegal
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_ext_pipe: XLEN must be 32 or 64");
   end

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] target;
      imm_type_e       itype;
      logic            illegal;
   } res_t;

   logic [XLEN-1:0] dec_imm;
   logic [XLEN-1:0] dec_target;
   imm_type_e       dec_type;
   logic            dec_illegal;
   res_t            dec_res;
   res_t            rd_res;
   res_t            mem [2];

   logic [1:0] count;
   logic       wptr;
   logic       rptr;
   logic       push;
   logic       pop;

   imm_decode #(.XLEN(XLEN)) u_dec (
      .inst    (in_inst),
      .pc      (in_pc),
      .imm     (dec_imm),
      .target  (dec_target),
      .itype   (dec_type),
      .illegal (dec_illegal)
   );

   assign dec_res = {dec_imm, dec_target, dec_type, dec_illegal};

   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   // Flush swallows any handshake that happens in the same cycle.
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   // Storage needs no reset: the read port is masked while empty.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= dec_res;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 2'd0;
         wptr  <= 1'b0;
         rptr  <= 1'b0;
      end else if (flush) begin
         count <= 2'd0;
         wptr  <= 1'b0;
         rptr  <= 1'b0;
      end else begin
         if (push) wptr <= ~wptr;
         if (pop)  rptr <= ~rptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: ;
         endcase
      end
   end

   assign rd_res      = out_valid ? mem[rptr] : '0;
   assign out_imm     = rd_res.imm;
   assign out_target  = rd_res.target;
   assign out_type    = rd_res.itype;
   assign out_illegal = rd_res.illegal;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: RV32 and RV64 instances share stimulus, each tracked
// by a queue-based reference model; directed cases pin literal values, then
// randomized traffic with backpressure and flushes.
module tb_imm_ext_pipe;

   typedef struct {
      logic [63:0] imm;
      logic [63:0] target;
      logic [2:0]  typ;
      logic        ill;
   } mdl_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_inst = '0;
   logic [63:0] in_pc = '0;

   logic        rdy32, vld32, ill32;
   logic [31:0] imm32, tgt32;
   logic [2:0]  typ32;
   logic        rdy64, vld64, ill64;
   logic [63:0] imm64, tgt64;
   logic [2:0]  typ64;

   int total = 0;
   int bad = 0;

   mdl_t q32[$];
   mdl_t q64[$];

   always #5 clk = ~clk;

   imm_ext_pipe #(.XLEN(32)) u32 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy32), .in_inst(in_inst), .in_pc(in_pc[31:0]),
      .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32), .out_target(tgt32),
      .out_type(typ32), .out_illegal(ill32)
   );

   imm_ext_pipe #(.XLEN(64)) u64 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy64), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64), .out_target(tgt64),
      .out_type(typ64), .out_illegal(ill64)
   );

   // Two's-complement sign extension of a 'bits'-wide field by arithmetic.
   function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
      logic [63:0] one;
      one = 64'd1;
      return v[bits-1] ? v - (one << bits) : v;
   endfunction

   function automatic mdl_t ref_decode(input logic [31:0] inst, input logic [63:0] pc,
                                       input bit x64);
      mdl_t        r;
      logic [63:0] mask;
      bit          tgt;
      logic [4:0]  op;
      r    = '{default: '0};
      mask = x64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      tgt  = 1'b0;
      op   = inst[6:2];
      if (inst[1:0] != 2'b11) begin
         r.ill = 1'b1;
         return r;
      end
      case (op)
         5'b00000, 5'b00100, 5'b11001: begin r.typ = 3'd1; r.imm = sx(64'(inst[31:20]), 12); end
         5'b00110: begin
            if (x64) begin r.typ = 3'd1; r.imm = sx(64'(inst[31:20]), 12); end
            else r.ill = 1'b1;
         end
         5'b01000: begin r.typ = 3'd2; r.imm = sx(64'({inst[31:25], inst[11:7]}), 12); end
         5'b11000: begin
            r.typ = 3'd3; tgt = 1'b1;
            r.imm = sx(64'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}), 13);
         end
         5'b01101: begin r.typ = 3'd4; r.imm = sx(64'({inst[31:12], 12'b0}), 32); end
         5'b00101: begin r.typ = 3'd4; tgt = 1'b1; r.imm = sx(64'({inst[31:12], 12'b0}), 32); end
         5'b11011: begin
            r.typ = 3'd5; tgt = 1'b1;
            r.imm = sx(64'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}), 21);
         end
         5'b11100: if (inst[14]) begin r.typ = 3'd6; r.imm = 64'(inst[19:15]); end
         default: ;
      endcase
      r.imm = r.imm & mask;
      if (tgt) r.target = (pc + r.imm) & mask;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp(input string tag, input logic rdy, input logic vld,
                      input logic [63:0] imm, input logic [63:0] tgt,
                      input logic [2:0] typ, input logic ill, input int sz, input mdl_t h);
      check({tag, ".in_ready"},  64'(rdy), 64'(sz != 2));
      check({tag, ".out_valid"}, 64'(vld), 64'(sz != 0));
      check({tag, ".imm"},       imm, h.imm);
      check({tag, ".target"},    tgt, h.target);
      check({tag, ".type"},      64'(typ), 64'(h.typ));
      check({tag, ".illegal"},   64'(ill), 64'(h.ill));
   endtask

   // Reference model: advances on the same edges as the DUTs, acceptance is
   // decided from the model's own occupancy.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || flush) begin
         q32.delete();
         q64.delete();
      end else begin
         if (in_valid && q32.size() != 2) begin
            if (out_ready && q32.size() != 0) void'(q32.pop_front());
            q32.push_back(ref_decode(in_inst, in_pc, 1'b0));
         end else if (out_ready && q32.size() != 0) void'(q32.pop_front());
         if (in_valid && q64.size() != 2) begin
            if (out_ready && q64.size() != 0) void'(q64.pop_front());
            q64.push_back(ref_decode(in_inst, in_pc, 1'b1));
         end else if (out_ready && q64.size() != 0) void'(q64.pop_front());
      end
   end

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk) begin
      mdl_t h;
      if (rst_n) begin
         h = '{default: '0};
         if (q32.size() != 0) h = q32[0];
         cmp("d32", rdy32, vld32, 64'(imm32), 64'(tgt32), typ32, ill32, q32.size(), h);
         h = '{default: '0};
         if (q64.size() != 0) h = q64[0];
         cmp("d64", rdy64, vld64, imm64, tgt64, typ64, ill64, q64.size(), h);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] i, input logic [63:0] p);
      in_valid = 1'b1;
      in_inst  = i;
      in_pc    = p;
      step();
      in_valid = 1'b0;
   endtask

   logic [4:0] ops [11] = '{5'b00000, 5'b00100, 5'b00110, 5'b11001, 5'b01000, 5'b11000,
                            5'b01101, 5'b00101, 5'b11011, 5'b11100, 5'b01100};

   initial begin
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      step();
      check("reset.in_ready", 64'(rdy32), 64'd1);
      check("reset.out_valid", 64'(vld32), 64'd0);
      check("reset.imm", 64'(imm32), 64'd0);

      // addi x1,x0,-1
      out_ready = 1'b1;
      send(32'hFFF0_0093, 64'h0);
      check("addi.imm", 64'(imm32), 64'h0000_0000_FFFF_FFFF);
      check("addi.type", 64'(typ32), 64'd1);
      check("addi.target", 64'(tgt32), 64'd0);
      check("addi.illegal", 64'(ill32), 64'd0);
      step();

      // beq -4, with and without wrap
      send(32'hFE00_0EE3, 64'h100);
      check("beq.imm", 64'(imm32), 64'h0000_0000_FFFF_FFFC);
      check("beq.target", 64'(tgt32), 64'h0000_0000_0000_00FC);
      check("beq.type", 64'(typ32), 64'd3);
      check("beq64.target", tgt64, 64'h0000_0000_0000_00FC);
      send(32'hFE00_0EE3, 64'h0);
      check("beq.wrap", 64'(tgt32), 64'h0000_0000_FFFF_FFFC);
      check("beq64.wrap", tgt64, 64'hFFFF_FFFF_FFFF_FFFC);

      // csrrwi zimm=31, then a compressed encoding
      send(32'h300F_D073, 64'h40);
      check("csrrwi.imm", 64'(imm32), 64'h1F);
      check("csrrwi.type", 64'(typ32), 64'd6);
      send(32'h0000_0001, 64'h40);
      check("c16.illegal", 64'(ill32), 64'd1);
      check("c16.type", 64'(typ32), 64'd0);
      check("c16.imm", 64'(imm32), 64'd0);

      // lui on both widths, addiw on both widths
      send(32'h8000_00B7, 64'h1234);
      check("lui64.imm", imm64, 64'hFFFF_FFFF_8000_0000);
      check("lui64.target", tgt64, 64'd0);
      check("lui32.imm", 64'(imm32), 64'h8000_0000);
      send(32'h0010_009B, 64'h0);
      check("addiw32.illegal", 64'(ill32), 64'd1);
      check("addiw32.imm", 64'(imm32), 64'd0);
      check("addiw64.type", 64'(typ64), 64'd1);
      check("addiw64.imm", imm64, 64'd1);
      step();

      // Backpressure: three offered back-to-back into a stalled sink
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_inst   = 32'h0050_0093; step();
      in_inst   = 32'h00A0_0093; step();
      in_inst   = 32'h00F0_0093;
      check("full.in_ready", 64'(rdy32), 64'd0);
      check("full.head", 64'(imm32), 64'd5);
      step(); step();
      check("hold.head", 64'(imm32), 64'd5);
      check("hold.in_ready", 64'(rdy32), 64'd0);
      out_ready = 1'b1;
      #1 check("full.rdy_indep", 64'(rdy32), 64'd0);
      step();
      check("drain.second", 64'(imm32), 64'd10);
      check("drain.reopen", 64'(rdy32), 64'd1);
      step();
      check("drain.third", 64'(imm32), 64'd15);
      check("drain.third_vld", 64'(vld32), 64'd1);
      in_valid = 1'b0;
      step();
      check("drain.empty", 64'(vld32), 64'd0);

      // Flush with two queued and a concurrent push
      out_ready = 1'b0;
      send(32'h0010_0093, 64'h0);
      send(32'h0020_0093, 64'h0);
      in_valid = 1'b1;
      flush    = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush.out_valid", 64'(vld32), 64'd0);
      check("flush.in_ready", 64'(rdy32), 64'd1);

      // Asynchronous reset with two queued
      send(32'h0030_0093, 64'h0);
      send(32'h0040_0093, 64'h0);
      #2 rst_n = 1'b0;
      #1;
      check("arst.out_valid", 64'(vld32), 64'd0);
      check("arst.imm", 64'(imm32), 64'd0);
      check("arst.in_ready", 64'(rdy32), 64'd1);
      check("arst64.imm", imm64, 64'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      step();
      out_ready = 1'b1;
      send(32'h0070_0093, 64'h0);
      check("arst.first_vld", 64'(vld32), 64'd1);
      check("arst.first_imm", 64'(imm32), 64'd7);
      step();

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         logic [31:0] w;
         int          k;
         w = $urandom;
         k = $urandom_range(0, 13);
         if (k <= 10) w[6:2] = ops[k];
         if ($urandom_range(0, 15) == 0) w[1:0] = 2'($urandom_range(0, 2));
         else w[1:0] = 2'b11;
         in_inst   = w;
         in_pc     = {$urandom, $urandom};
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 49) == 0);
         step();
      end
      in_valid = 1'b0;
      flush    = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
